branch_resolve: RTL

Resolves conditional branches and `jr` in the decode stage and issues the PC redirect to fetch. It sits directly downstream of `fastforward` and consumes its `s_loaduse`, `s_branch_jr_ok`, `*_fastforward_bj` and `d_*_fastforward` outputs. It selects forwarded or register-file operands, evaluates the branch condition, and drives a valid/ready redirect to the fetch stage. It also raises the decode stall while operands are not yet safe.

---
 rtl/branch_resolve_pkg.sv | 28 ++
 rtl/branch_resolve_if.sv | 24 ++
 rtl/branch_resolve_branch_cond.sv | 32 +++
 rtl/branch_resolve.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared widths, branch condition codes, FSM state
// encoding and the branch-target helper for the decode-stage resolver.
package branch_resolve_pkg;

    localparam int DATA_W           = 32;
    localparam int BR_OFF_W         = 16;
    localparam int BUS_DECODE_BR_OP = 3;

    localparam logic [BUS_DECODE_BR_OP-1:0] BR_OP_BEQ  = 3'd0;
    localparam logic [BUS_DECODE_BR_OP-1:0] BR_OP_BNE  = 3'd1;
    localparam logic [BUS_DECODE_BR_OP-1:0] BR_OP_BLEZ = 3'd2;
    localparam logic [BUS_DECODE_BR_OP-1:0] BR_OP_BGTZ = 3'd3;
    localparam logic [BUS_DECODE_BR_OP-1:0] BR_OP_BLTZ = 3'd4;
    localparam logic [BUS_DECODE_BR_OP-1:0] BR_OP_BGEZ = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_OPND = 2'd1,
        ST_HOLD      = 2'd2
    } br_state_e;

    // pc_plus4 + (sign-extended offset << 2); wraps modulo 2^32.
    function automatic logic [DATA_W-1:0] br_target(input logic [DATA_W-1:0] pc_plus4,
                                                    input logic [BR_OFF_W-1:0] off);
        return pc_plus4 + {{(DATA_W-BR_OFF_W-2){off[BR_OFF_W-1]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: valid/ready PC redirect channel from decode to fetch.
interface branch_resolve_if;
    import branch_resolve_pkg::*;

    logic              redirect_valid;
    logic              redirect_ready;
    logic [DATA_W-1:0] redirect_target;
    logic              redirect_misalign;

    modport master (
        output redirect_valid,
        output redirect_target,
        output redirect_misalign,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_target,
        input  redirect_misalign,
        output redirect_ready
    );

endinterface

// File: rtl/branch_resolve_branch_cond.sv
// branch_cond: combinational branch condition evaluation. Signed compares
// against zero reduce to the sign bit plus a zero test of op_rs.
module branch_cond
    import branch_resolve_pkg::*;
(
    input  logic [BUS_DECODE_BR_OP-1:0] br_op,
    input  logic [DATA_W-1:0]           op_rs,
    input  logic [DATA_W-1:0]           op_rt,
    output logic                        taken
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = op_rs[DATA_W-1];
    assign rs_zero = (op_rs == '0);

    // Decode the condition code; reserved codes are never taken.
    always_comb begin
        taken = 1'b0;
        case (br_op)
            BR_OP_BEQ:  taken = (op_rs == op_rt);
            BR_OP_BNE:  taken = (op_rs != op_rt);
            BR_OP_BLEZ: taken = rs_neg | rs_zero;
            BR_OP_BGTZ: taken = ~rs_neg & ~rs_zero;
            BR_OP_BLTZ: taken = rs_neg;
            BR_OP_BGEZ: taken = ~rs_neg;
            default:    taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves conditional branches and jr in decode and issues a
// registered valid/ready PC redirect to fetch. Raises stall_id while operands
// are unsafe or a new request is blocked behind an unaccepted redirect.
// Optional feature macro: BRANCH_STATS_EN adds stat_taken / stat_stall.
module branch_resolve
    import branch_resolve_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        PIPELINE_READY,
    input  logic                        id_valid,
    input  logic                        s_branch,
    input  logic                        s_jr,
    input  logic [BUS_DECODE_BR_OP-1:0] br_op,
    input  logic [BR_OFF_W-1:0]         br_offset,
    input  logic [DATA_W-1:0]           pc_plus4,
    input  logic                        s_loaduse,
    input  logic                        s_branch_jr_ok,
    input  logic [DATA_W-1:0]           rf_rs_data,
    input  logic [DATA_W-1:0]           rf_rt_data,
    input  logic                        s_rs_fastforward_bj,
    input  logic                        s_rt_fastforward_bj,
    input  logic [DATA_W-1:0]           d_rs_fastforward,
    input  logic [DATA_W-1:0]           d_rt_fastforward,
    branch_resolve_if.master            rd,
    output logic                        stall_id
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]                 stat_taken,
    output logic [31:0]                 stat_stall
`endif
);

    logic [DATA_W-1:0] op_rs;
    logic [DATA_W-1:0] op_rt;
    logic              cond_taken;
    logic              req;
    logic              resolvable;
    logic              taken;
    logic              handshake;
    logic [DATA_W-1:0] new_target;
    logic              new_misalign;
    logic              load;

    br_state_e         state_q, state_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              misalign_q, misalign_d;

    assign op_rs = s_rs_fastforward_bj ? d_rs_fastforward : rf_rs_data;
    assign op_rt = s_rt_fastforward_bj ? d_rt_fastforward : rf_rt_data;

    branch_cond u_cond (
        .br_op (br_op),
        .op_rs (op_rs),
        .op_rt (op_rt),
        .taken (cond_taken)
    );

    assign req          = id_valid & (s_branch | s_jr);
    assign resolvable   = req & s_branch_jr_ok & ~s_loaduse;
    // jr wins if both flags are somehow set: it is unconditional.
    assign taken        = s_jr | cond_taken;
    assign new_target   = s_jr ? op_rs : br_target(pc_plus4, br_offset);
    assign new_misalign = s_jr & (|op_rs[1:0]);

    // The redirect is outstanding exactly while the FSM sits in HOLD.
    assign rd.redirect_valid    = (state_q == ST_HOLD);
    assign rd.redirect_target   = target_q;
    assign rd.redirect_misalign = misalign_q;
    assign handshake            = rd.redirect_valid & rd.redirect_ready;

    // Next-state and redirect load. Leaving HOLD on handshake is not gated by
    // PIPELINE_READY; loading a new redirect is.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        misalign_d = misalign_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PIPELINE_READY && req) begin
                    if (!resolvable)  state_d = ST_WAIT_OPND;
                    else if (taken)   load    = 1'b1;
                end
            end
            ST_WAIT_OPND: begin
                if (PIPELINE_READY) begin
                    if (!req)             state_d = ST_IDLE;
                    else if (resolvable) begin
                        if (taken)        load    = 1'b1;
                        else              state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    if (PIPELINE_READY && resolvable && taken) load    = 1'b1;
                    else                                       state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d    = ST_HOLD;
            target_d   = new_target;
            misalign_d = new_misalign;
        end
    end

    // State and redirect registers; reset drops any pending redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            misalign_q <= misalign_d;
        end
    end

    // Stall while operands are unsafe, or while a new request waits behind an
    // unaccepted redirect. Forced low during reset.
    always_comb begin
        stall_id = reset_n & ((req & ~resolvable) |
                              (rd.redirect_valid & req & ~rd.redirect_ready));
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating event counters, frozen while the pipeline is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (PIPELINE_READY) begin
            if (handshake && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + 32'd1;
            if (stall_id  && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stat_taken = taken_cnt_q;
    assign stat_stall = stall_cnt_q;
`endif

endmodule
